// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, fetches over a req/ack imem port and feeds the IF/ID register.
// Optional performance counters are enabled with `define FETCH_PERF_CNT_EN.
module instr_fetch_unit #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int          CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [15:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [15:0]      imem_rdata,
    input  logic             id_ready,
    output logic             if_id_valid,
    output logic [15:0]      if_id_instr,
    output logic [15:0]      if_id_pc_plus2,
    output logic [3:0]       opcode,
    input  logic             ex_valid,
    input  logic             ex_beq,
    input  logic             ex_bne,
    input  logic             ex_jump,
    input  logic             ex_zero,
    input  logic [15:0]      ex_pc_plus2,
    input  logic [11:0]      ex_imm,
    output logic [CNT_W-1:0] perf_fetched,
    output logic [CNT_W-1:0] perf_flushes
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_t;

    state_t      state, state_nxt;
    logic [15:0] pc, pc_nxt, pc_plus2, stale_addr;
    logic [15:0] skid_instr, skid_pc_plus2;
    logic [15:0] target;
    logic        ack, taken;
    logic        load_mem, load_skid, load_from_skid;

    assign pc_plus2  = pc + 16'd2;
    assign ack       = imem_ack & imem_req;
    assign taken     = ex_valid & (ex_jump | (ex_beq & ex_zero) | (ex_bne & ~ex_zero));
    assign target    = ex_jump ? {ex_pc_plus2[15:13], ex_imm, 1'b0}
                               : ex_pc_plus2 + {{9{ex_imm[5]}}, ex_imm[5:0], 1'b0};
    assign imem_req  = (state == S_REQ) || (state == S_DISCARD);
    // While discarding, the PC already points at the redirect target.
    assign imem_addr = (state == S_DISCARD) ? stale_addr : pc;
    assign opcode    = if_id_instr[15:12];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        load_mem       = 1'b0;
        load_skid      = 1'b0;
        load_from_skid = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_REQ;
            S_REQ: begin
                if (ack) begin
                    pc_nxt = pc_plus2;
                    if (!if_id_valid || id_ready) begin
                        load_mem = 1'b1;
                    end else begin
                        load_skid = 1'b1;
                        state_nxt = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (id_ready) begin
                    load_from_skid = 1'b1;
                    state_nxt      = S_REQ;
                end
            end
            S_DISCARD: if (ack) state_nxt = S_REQ;
            default: state_nxt = S_IDLE;
        endcase
        // A taken redirect overrides every other event of the cycle.
        if (taken) begin
            load_mem       = 1'b0;
            load_skid      = 1'b0;
            load_from_skid = 1'b0;
            pc_nxt         = target;
            state_nxt      = (imem_req && !imem_ack) ? S_DISCARD : S_REQ;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            stale_addr <= RESET_PC;
        end else begin
            pc <= pc_nxt;
            if (state == S_REQ && state_nxt == S_DISCARD) stale_addr <= pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_id_valid    <= 1'b0;
            if_id_instr    <= 16'h0000;
            if_id_pc_plus2 <= 16'h0000;
            skid_instr     <= 16'h0000;
            skid_pc_plus2  <= 16'h0000;
        end else begin
            if (taken) begin
                if_id_valid <= 1'b0;
            end else if (load_mem) begin
                if_id_valid    <= 1'b1;
                if_id_instr    <= imem_rdata;
                if_id_pc_plus2 <= pc_plus2;
            end else if (load_from_skid) begin
                if_id_valid    <= 1'b1;
                if_id_instr    <= skid_instr;
                if_id_pc_plus2 <= skid_pc_plus2;
            end else if (id_ready) begin
                if_id_valid <= 1'b0;
            end
            if (load_skid) begin
                skid_instr    <= imem_rdata;
                skid_pc_plus2 <= pc_plus2;
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [CNT_W-1:0] fetched_cnt, flush_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetched_cnt <= '0;
            flush_cnt   <= '0;
        end else begin
            if (load_mem || load_from_skid) fetched_cnt <= fetched_cnt + CNT_W'(1);
            if (taken)                      flush_cnt   <= flush_cnt + CNT_W'(1);
        end
    end

    assign perf_fetched = fetched_cnt;
    assign perf_flushes = flush_cnt;
`else
    assign perf_fetched = '0;
    assign perf_flushes = '0;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized run checked against
// a program-order model (expected fetch stream, redirect targets, request stability).
module tb_instr_fetch_unit;

    localparam logic [15:0] RESET_PC = 16'h0000;
    localparam int          CNT_W    = 16;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             imem_req;
    logic [15:0]      imem_addr;
    logic             imem_ack;
    logic [15:0]      imem_rdata;
    logic             id_ready;
    logic             if_id_valid;
    logic [15:0]      if_id_instr;
    logic [15:0]      if_id_pc_plus2;
    logic [3:0]       opcode;
    logic             ex_valid, ex_beq, ex_bne, ex_jump, ex_zero;
    logic [15:0]      ex_pc_plus2;
    logic [11:0]      ex_imm;
    logic [CNT_W-1:0] perf_fetched;
    logic [CNT_W-1:0] perf_flushes;

    int n_cmp = 0;
    int n_err = 0;

    instr_fetch_unit #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .id_ready(id_ready), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc_plus2(if_id_pc_plus2), .opcode(opcode),
        .ex_valid(ex_valid), .ex_beq(ex_beq), .ex_bne(ex_bne), .ex_jump(ex_jump), .ex_zero(ex_zero),
        .ex_pc_plus2(ex_pc_plus2), .ex_imm(ex_imm),
        .perf_fetched(perf_fetched), .perf_flushes(perf_flushes)
    );

    always #5 clk = ~clk;

    // Instruction memory contents as a pure function of the address.
    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h3C5A;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_ex();
        ex_valid = 0; ex_beq = 0; ex_bne = 0; ex_jump = 0; ex_zero = 0;
        ex_pc_plus2 = 16'h0000; ex_imm = 12'h000;
    endtask

    task automatic do_reset();
        rst_n = 0; imem_ack = 0; imem_rdata = 16'h0000; id_ready = 0;
        clear_ex();
        step(); step();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        rst_n = 0;
        step();
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b expected 0", imem_req); end
        n_cmp++; if (if_id_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", if_id_valid); end
        n_cmp++; if (if_id_instr !== 16'h0000) begin n_err++; $display("FAIL reset_instr: got %h expected 0000", if_id_instr); end
        n_cmp++; if (if_id_pc_plus2 !== 16'h0000) begin n_err++; $display("FAIL reset_pc_plus2: got %h expected 0000", if_id_pc_plus2); end
        n_cmp++; if (imem_addr !== RESET_PC) begin n_err++; $display("FAIL reset_addr: got %h expected %h", imem_addr, RESET_PC); end
        n_cmp++; if (perf_fetched !== '0 || perf_flushes !== '0) begin n_err++; $display("FAIL reset_perf: got %h/%h expected 0/0", perf_fetched, perf_flushes); end
        rst_n = 1;
        #1;
        n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL idle_req: got %b expected 0", imem_req); end
        step();
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== RESET_PC) begin n_err++; $display("FAIL first_req: got req=%b addr=%h expected req=1 addr=%h", imem_req, imem_addr, RESET_PC); end
    endtask

    task automatic test_sequential();
        logic [15:0] d;
        do_reset();
        step();
        id_ready = 1;
        for (int i = 0; i < 6; i++) begin
            n_cmp++;
            if (imem_req !== 1'b1 || imem_addr !== RESET_PC + 16'(2 * i)) begin
                n_err++; $display("FAIL seq_addr%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, RESET_PC + 16'(2 * i));
            end
            d = 16'($urandom);
            imem_ack = 1; imem_rdata = d;
            step();
            n_cmp++;
            if (if_id_valid !== 1'b1 || opcode !== d[15:12] || if_id_instr !== d || if_id_pc_plus2 !== RESET_PC + 16'(2 * i + 2)) begin
                n_err++; $display("FAIL seq_ifid%0d: got v=%b op=%h instr=%h pc2=%h expected v=1 op=%h instr=%h pc2=%h",
                                  i, if_id_valid, opcode, if_id_instr, if_id_pc_plus2, d[15:12], d, RESET_PC + 16'(2 * i + 2));
            end
        end
        imem_ack = 0;
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_fetched !== 16'd6) begin n_err++; $display("FAIL seq_perf_fetched: got %0d expected 6", perf_fetched); end
`else
        n_cmp++; if (perf_fetched !== 16'd0) begin n_err++; $display("FAIL seq_perf_fetched: got %0d expected 0", perf_fetched); end
`endif
    endtask

    task automatic test_skid();
        logic [15:0] a;
        do_reset();
        step();
        a = 16'($urandom);
        id_ready = 0; imem_ack = 1; imem_rdata = a;
        step();
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== a || imem_addr !== 16'h0002 || imem_req !== 1'b1) begin
            n_err++; $display("FAIL skid_first: got v=%b instr=%h addr=%h req=%b expected v=1 instr=%h addr=0002 req=1", if_id_valid, if_id_instr, imem_addr, imem_req, a);
        end
        imem_rdata = 16'h2123;
        step();
        n_cmp++; if (imem_req !== 1'b0 || if_id_instr !== a) begin n_err++; $display("FAIL skid_hold: got req=%b instr=%h expected req=0 instr=%h", imem_req, if_id_instr, a); end
        imem_rdata = 16'hFFFF;  // stray ack while no request is pending
        step();
        n_cmp++; if (imem_req !== 1'b0 || if_id_instr !== a || if_id_valid !== 1'b1) begin
            n_err++; $display("FAIL skid_stray_ack: got req=%b instr=%h v=%b expected req=0 instr=%h v=1", imem_req, if_id_instr, if_id_valid, a);
        end
        imem_ack = 0;
        step();
        id_ready = 1;
        step();
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== 16'h2123 || if_id_pc_plus2 !== 16'h0004 || imem_req !== 1'b1 || imem_addr !== 16'h0004) begin
            n_err++; $display("FAIL skid_release: got v=%b instr=%h pc2=%h req=%b addr=%h expected v=1 instr=2123 pc2=0004 req=1 addr=0004",
                              if_id_valid, if_id_instr, if_id_pc_plus2, imem_req, imem_addr);
        end
        step();
        n_cmp++; if (if_id_valid !== 1'b0 || imem_addr !== 16'h0004) begin
            n_err++; $display("FAIL skid_consumed: got v=%b addr=%h expected v=0 addr=0004", if_id_valid, imem_addr);
        end
    endtask

    task automatic test_branch();
        logic [15:0] x;
        do_reset();
        step();
        id_ready = 0; imem_ack = 1; imem_rdata = 16'($urandom);
        step();
        imem_ack = 0;
        ex_valid = 1; ex_beq = 1; ex_zero = 0; ex_pc_plus2 = 16'h0010; ex_imm = 12'h03E;
        step();
        n_cmp++; if (if_id_valid !== 1'b1 || imem_addr !== 16'h0002) begin
            n_err++; $display("FAIL beq_not_taken: got v=%b addr=%h expected v=1 addr=0002", if_id_valid, imem_addr);
        end
        ex_zero = 1; imem_ack = 1; imem_rdata = 16'($urandom);
        step();
        clear_ex();
        n_cmp++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h000C) begin
            n_err++; $display("FAIL beq_taken: got v=%b req=%b addr=%h expected v=0 req=1 addr=000C", if_id_valid, imem_req, imem_addr);
        end
        x = 16'($urandom);
        imem_rdata = x;
        step();
        imem_ack = 0;
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== x || if_id_pc_plus2 !== 16'h000E) begin
            n_err++; $display("FAIL beq_target_fetch: got v=%b instr=%h pc2=%h expected v=1 instr=%h pc2=000E", if_id_valid, if_id_instr, if_id_pc_plus2, x);
        end
    endtask

    task automatic test_jump();
        do_reset();
        step();
        ex_valid = 1; ex_jump = 1; ex_beq = 1; ex_zero = 0; ex_pc_plus2 = 16'hA004; ex_imm = 12'h123;
        imem_ack = 1; imem_rdata = 16'($urandom);
        step();
        imem_ack = 0;
        n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'hA246 || if_id_valid !== 1'b0) begin
            n_err++; $display("FAIL jump_target: got req=%b addr=%h v=%b expected req=1 addr=A246 v=0", imem_req, imem_addr, if_id_valid);
        end
`ifdef FETCH_PERF_CNT_EN
        n_cmp++; if (perf_flushes !== 16'd1) begin n_err++; $display("FAIL jump_perf_flushes: got %0d expected 1", perf_flushes); end
`else
        n_cmp++; if (perf_flushes !== 16'd0) begin n_err++; $display("FAIL jump_perf_flushes: got %0d expected 0", perf_flushes); end
`endif
        ex_valid = 0; ex_pc_plus2 = 16'h1000;
        step();
        clear_ex();
        n_cmp++; if (imem_addr !== 16'hA246) begin n_err++; $display("FAIL jump_gated: got addr=%h expected A246", imem_addr); end
    endtask

    task automatic test_discard();
        logic [15:0] x;
        do_reset();
        step();
        ex_valid = 1; ex_jump = 1; ex_pc_plus2 = 16'h0000; ex_imm = 12'h040;
        step();
        clear_ex();
        for (int k = 0; k < 2; k++) begin
            n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000 || if_id_valid !== 1'b0) begin
                n_err++; $display("FAIL discard_stale%0d: got req=%b addr=%h v=%b expected req=1 addr=0000 v=0", k, imem_req, imem_addr, if_id_valid);
            end
            step();
        end
        id_ready = 1; imem_ack = 1; imem_rdata = 16'hD000;
        step();
        n_cmp++; if (if_id_valid !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 16'h0080) begin
            n_err++; $display("FAIL discard_drop: got v=%b req=%b addr=%h expected v=0 req=1 addr=0080", if_id_valid, imem_req, imem_addr);
        end
        x = 16'($urandom);
        imem_rdata = x;
        step();
        imem_ack = 0;
        n_cmp++; if (if_id_valid !== 1'b1 || if_id_instr !== x || if_id_pc_plus2 !== 16'h0082) begin
            n_err++; $display("FAIL discard_refetch: got v=%b instr=%h pc2=%h expected v=1 instr=%h pc2=0082", if_id_valid, if_id_instr, if_id_pc_plus2, x);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        do_reset();
        step();
        ex_valid = 1; ex_jump = 1; ex_pc_plus2 = 16'hE000; ex_imm = 12'hFFF;
        imem_ack = 1; imem_rdata = 16'($urandom); id_ready = 1;
        step();
        clear_ex();
        n_cmp++; if (imem_addr !== 16'hFFFE) begin n_err++; $display("FAIL wrap_setup: got addr=%h expected FFFE", imem_addr); end
        imem_rdata = 16'($urandom);
        step();
        n_cmp++; if (imem_addr !== 16'h0000 || if_id_pc_plus2 !== 16'h0000 || if_id_valid !== 1'b1) begin
            n_err++; $display("FAIL wrap_pc: got addr=%h pc2=%h v=%b expected addr=0000 pc2=0000 v=1", imem_addr, if_id_pc_plus2, if_id_valid);
        end
        step();
        imem_ack = 0;
        #2;
        rst_n = 0;
        #1;
        n_cmp++; if (imem_req !== 1'b0 || if_id_valid !== 1'b0 || imem_addr !== RESET_PC) begin
            n_err++; $display("FAIL async_reset: got req=%b v=%b addr=%h expected req=0 v=0 addr=%h", imem_req, if_id_valid, imem_addr, RESET_PC);
        end
        step();
        rst_n = 1;
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, held_addr, redir_tgt, tgt;
        logic        held, exp_redir, disc, tk;
        int          flushes, consumed;
        do_reset();
        exp_pc = RESET_PC; held = 0; exp_redir = 0; disc = 0;
        held_addr = 16'h0000; redir_tgt = 16'h0000;
        flushes = 0; consumed = 0;
        for (int i = 0; i < 4000; i++) begin
            if (exp_redir) begin
                n_cmp++; if (imem_req !== 1'b1 || imem_addr !== redir_tgt) begin
                    n_err++; $display("FAIL rnd_redirect@%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, redir_tgt);
                end
                exp_redir = 0;
            end
            if (held) begin
                n_cmp++; if (imem_req !== 1'b1 || imem_addr !== held_addr) begin
                    n_err++; $display("FAIL rnd_req_stable@%0d: got req=%b addr=%h expected req=1 addr=%h", i, imem_req, imem_addr, held_addr);
                end
            end
            if (if_id_valid === 1'b1 && opcode !== if_id_instr[15:12]) begin
                n_cmp++; n_err++;
                $display("FAIL rnd_opcode@%0d: got %h expected %h", i, opcode, if_id_instr[15:12]);
            end
            if (i % 256 == 0) begin
                n_cmp++;
`ifdef FETCH_PERF_CNT_EN
                if (perf_flushes !== 16'(flushes)) begin n_err++; $display("FAIL rnd_perf_flushes@%0d: got %0d expected %0d", i, perf_flushes, flushes); end
`else
                if (perf_flushes !== '0 || perf_fetched !== '0) begin n_err++; $display("FAIL rnd_perf_off@%0d: got %0d/%0d expected 0/0", i, perf_fetched, perf_flushes); end
`endif
            end
            id_ready    = ($urandom_range(0, 3) != 0);
            imem_ack    = imem_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 9) == 0);
            imem_rdata  = (imem_ack && imem_req) ? mem_word(imem_addr) : 16'($urandom);
            ex_valid    = ($urandom_range(0, 15) == 0);
            ex_jump     = ($urandom_range(0, 2) == 0);
            ex_beq      = 1'($urandom);
            ex_bne      = 1'($urandom);
            ex_zero     = 1'($urandom);
            ex_pc_plus2 = 16'($urandom) & 16'hFFFE;
            ex_imm      = 12'($urandom);
            tk  = ex_valid && (ex_jump || (ex_beq && ex_zero) || (ex_bne && !ex_zero));
            if (ex_jump) tgt = {ex_pc_plus2[15:13], ex_imm, 1'b0};
            else         tgt = 16'(int'(ex_pc_plus2) + 2 * int'($signed(ex_imm[5:0])));
            if (if_id_valid && id_ready && !tk) begin
                n_cmp++; consumed++;
                if (if_id_instr !== mem_word(exp_pc) || if_id_pc_plus2 !== exp_pc + 16'd2) begin
                    n_err++; $display("FAIL rnd_stream@%0d: got instr=%h pc2=%h expected instr=%h pc2=%h", i, if_id_instr, if_id_pc_plus2, mem_word(exp_pc), exp_pc + 16'd2);
                end
                exp_pc = exp_pc + 16'd2;
            end
            held      = imem_req && !imem_ack;
            held_addr = imem_addr;
            if (tk) begin
                exp_pc = tgt; redir_tgt = tgt; flushes++;
                if (imem_req && !imem_ack) disc = 1;
                else begin disc = 0; exp_redir = 1; end
            end else if (disc && imem_req && imem_ack) begin
                disc = 0; exp_redir = 1;
            end
            step();
        end
        clear_ex();
        imem_ack = 0;
        n_cmp++; if (consumed < 100) begin n_err++; $display("FAIL rnd_progress: got %0d consumed expected at least 100", consumed); end
    endtask

    initial begin
        imem_ack = 0; imem_rdata = 16'h0000; id_ready = 0;
        clear_ex();
        test_reset();
        test_sequential();
        test_skid();
        test_branch();
        test_jump();
        test_discard();
        test_wrap_and_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
